// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits and an idle guard, paced by an internal baud divider.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int GUARD_BITS   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_two_stop,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int                BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]        GUARD_LAST = 4'((GUARD_BITS > 0) ? GUARD_BITS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GUARD  = 3'd5
    } state_t;

    state_t               state, next_state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [3:0]           bit_cnt;
    logic [3:0]           guard_cnt;
    logic [DATA_BITS-1:0] shift_q, shift_next;
    logic                 parity_en_q, parity_bit_q, two_stop_q;
    logic                 baud_done, accept, tx_next, done_next;

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign accept    = i_tx_valid && (state == S_IDLE);

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        // NOTE: default assignment up front so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            S_IDLE:   if (accept)    next_state = S_START;
            S_START:  if (baud_done) next_state = S_DATA;
            S_DATA:   if (baud_done && bit_cnt == DATA_LAST)
                          next_state = parity_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (baud_done) next_state = S_STOP;
            S_STOP:   if (baud_done && bit_cnt == {3'b000, two_stop_q})
                          next_state = (GUARD_BITS > 0) ? S_GUARD : S_IDLE;
            S_GUARD:  if (baud_done && guard_cnt == GUARD_LAST) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // o_tx is driven from the next state so the start bit appears the cycle after accept.
    always_comb begin
        shift_next = shift_q;
        if (accept)
            shift_next = i_tx_data;
        else if (state == S_DATA && baud_done)
            shift_next = shift_q >> 1;

        case (next_state)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = parity_bit_q;
            default:  tx_next = 1'b1;
        endcase

        done_next  = (state == S_STOP || state == S_GUARD) && (next_state == S_IDLE);
        o_busy     = (state != S_IDLE);
        o_tx_ready = (state == S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the shift register is a handful of flops, so it is reset with everything else.
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            guard_cnt    <= '0;
            shift_q      <= '0;
            parity_en_q  <= 1'b0;
            parity_bit_q <= 1'b0;
            two_stop_q   <= 1'b0;
            o_tx         <= 1'b1;
            o_done       <= 1'b0;
        end else begin
            baud_cnt <= (state == S_IDLE || baud_done) ? '0 : baud_cnt + 1'b1;

            if (next_state != state)
                bit_cnt <= '0;
            else if (baud_done && (state == S_DATA || state == S_STOP))
                bit_cnt <= bit_cnt + 4'd1;

            if (next_state != state)
                guard_cnt <= '0;
            else if (baud_done && state == S_GUARD)
                guard_cnt <= guard_cnt + 4'd1;

            shift_q <= shift_next;

            // Frame options are frozen at accept; later input changes are ignored.
            if (accept) begin
                parity_en_q  <= ^i_parity_mode;
                parity_bit_q <= i_parity_mode[1] ? ~^i_tx_data : ^i_tx_data;
                two_stop_q   <= i_two_stop;
            end

            o_tx   <= tx_next;
            o_done <= done_next;
        end
    end

endmodule
